// File: rtl/piso_shift_pkg.sv
// Shared types and constants for the PISO shift transmitter and its receiver bench.
package piso_shift_pkg;

    localparam int PISO_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Wide enough to hold WIDTH-1 with headroom.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: reloads to zero on a new word and counts enabled shifts.
// Saturates at WIDTH-1, where o_tc flags the last data bit.
module piso_bit_counter
    import piso_shift_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH,
    parameter int CW    = cnt_w(WIDTH)
) (
    input  logic clk,
    input  logic clrb,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= '0;
        else if (i_en && !o_tc)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: captures a word on load handshake, shifts it out
// one bit per enabled clock. Define PISO_SHIFT_TX_PARITY_EN to append an even parity bit.
module piso_shift_tx
    import piso_shift_pkg::*;
#(
    parameter int WIDTH     = PISO_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clrb,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             busy,
    output logic             done
);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic             r_done, w_done_nxt;
    logic             w_load, w_step, w_tc;
`ifdef PISO_SHIFT_TX_PARITY_EN
    logic             r_par;
`endif

    assign w_load = load_valid && (r_state == IDLE);
    assign w_step = shift_en && (r_state == SHIFT);

    piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .clrb   (clrb),
        .i_load (w_load),
        .i_en   (w_step),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: if (w_load) w_state_nxt = SHIFT;
            SHIFT: begin
                if (shift_en && w_tc) begin
`ifdef PISO_SHIFT_TX_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
`endif
                end
            end
`ifdef PISO_SHIFT_TX_PARITY_EN
            PARITY: begin
                if (shift_en) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // Vacated bit fills with zero so the register drains to 0 at frame end.
    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb)
            r_shreg <= '0;
        else if (w_load)
            r_shreg <= din;
        else if (w_step)
            r_shreg <= LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);
    end

`ifdef PISO_SHIFT_TX_PARITY_EN
    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb)
            r_par <= 1'b0;
        else if (w_load)
            r_par <= ^din;
    end
`endif

    always_comb begin
        sdo       = 1'b0;
        sdo_valid = 1'b0;
        case (r_state)
            SHIFT: begin
                sdo       = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
                sdo_valid = 1'b1;
            end
`ifdef PISO_SHIFT_TX_PARITY_EN
            PARITY: begin
                sdo       = r_par;
                sdo_valid = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign load_ready = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign done       = r_done;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench: LSB-first and MSB-first transmitters side by side, plus a right-shift
// SIPO receiving the LSB-first line.
module tb_piso_shift_tx;
    import piso_shift_pkg::*;

    localparam int W = PISO_WIDTH;
`ifdef PISO_SHIFT_TX_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         clrb;
    logic [W-1:0] din;
    logic         load_valid, shift_en;
    logic         rdy_l, sdo_l, vld_l, busy_l, done_l;
    logic         rdy_m, sdo_m, vld_m, busy_m, done_m;
    logic [W-1:0] q;
    int           n_chk = 0;
    int           n_err = 0;

    always #50 clk = ~clk;

    piso_shift_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .clrb(clrb), .din(din), .load_valid(load_valid), .load_ready(rdy_l),
        .shift_en(shift_en), .sdo(sdo_l), .sdo_valid(vld_l), .busy(busy_l), .done(done_l)
    );

    piso_shift_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .clrb(clrb), .din(din), .load_valid(load_valid), .load_ready(rdy_m),
        .shift_en(shift_en), .sdo(sdo_m), .sdo_valid(vld_m), .busy(busy_m), .done(done_m)
    );

    // Right-shift SIPO: first bit received ends up in q[0].
    always @(posedge clk or negedge clrb) begin
        if (!clrb)
            q <= '0;
        else if (vld_l && shift_en)
            q <= {sdo_l, q[W-1:1]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Load w at the next posedge, then walk the frame, optionally stalling at bit stall_at
    // for stall_n cycles and offering a bogus word mid-frame.
    task automatic frame(input logic [W-1:0] w, input int stall_at, input int stall_n,
                         input bit intrude);
        int b = 0;
        int cyc = 0;
        int stalled = 0;
        logic exp_l, exp_m;
        bit hold;
        din = w; load_valid = 1'b1; shift_en = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        din = 4'b0110;
        while (b < NB) begin
            exp_l = (b < W) ? w[b]       : ^w;
            exp_m = (b < W) ? w[W-1-b]   : ^w;
            chk($sformatf("sdo_l b%0d", b), sdo_l, exp_l);
            chk($sformatf("sdo_m b%0d", b), sdo_m, exp_m);
            chk("sdo_valid", {vld_l, vld_m}, 2'b11);
            if (cyc == 0) chk("busy/rdy mid", {busy_l, rdy_l, done_l}, 3'b100);
            hold = (b == stall_at) && (stalled < stall_n);
            shift_en = !hold;
            if (hold) stalled++; else b++;
            load_valid = intrude && (cyc == 1);
            cyc++;
            @(negedge clk);
        end
        shift_en = 1'b1;
        load_valid = 1'b0;
        chk("done pulse", {done_l, done_m}, 2'b11);
        chk("idle out", {vld_l, vld_m, sdo_l, sdo_m, busy_l, rdy_l}, 6'b000001);
`ifndef PISO_SHIFT_TX_PARITY_EN
        chk("sipo q", q, w);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clrb = 1'b0; din = '0; load_valid = 1'b0; shift_en = 1'b1;
        #10;
        chk("reset", {sdo_l, vld_l, busy_l, done_l, rdy_l}, 5'b00001);
        @(negedge clk);
        clrb = 1'b1;
        @(negedge clk);
        chk("post reset idle", {vld_l, busy_l, rdy_l, done_l}, 4'b0010);

        frame(4'b1011, -1, 0, 1'b0);
        @(negedge clk);
        chk("done drops", {done_l, done_m}, 2'b00);

        frame(4'b1011, 1, 2, 1'b0);
        @(negedge clk);

        frame(4'b1011, -1, 0, 1'b1);
        // back-to-back: new word loaded in the done cycle
        frame(4'b0110, -1, 0, 1'b0);
        frame(4'b1000, -1, 0, 1'b0);
        @(negedge clk);
        chk("done drops b2b", done_l, 1'b0);

        // reset two bits into a frame
        din = 4'b1011; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid frame sdo", {sdo_l, vld_l, busy_l}, 3'b011);
        clrb = 1'b0;
        #1;
        chk("async reset", {sdo_l, vld_l, busy_l, rdy_l, done_l}, 5'b00010);
        @(negedge clk);
        clrb = 1'b1;
        @(negedge clk);
        chk("no done after abort", {done_l, done_m, busy_l}, 3'b000);

        frame(4'b0101, -1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
